// File: rtl/reg_file_sequencer_if.sv
// Control, load-stream, register-file and dump-stream signals of reg_file_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface reg_file_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_start_load;
  logic              i_start_dump;
  logic              i_abort;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] rw_reg;
  logic              reg_write;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rs1_reg;
  logic [DATA_W-1:0] rs1_read;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_idx;
  logic              m_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  i_start_load, i_start_dump, i_abort, s_valid, s_data, rs1_read, m_ready,
    output s_ready, rw_reg, reg_write, wr_data, rs1_reg, m_valid, m_data, m_idx, busy, done
  );

  modport master (
    output i_start_load, i_start_dump, i_abort, s_valid, s_data, rs1_read, m_ready,
    input  s_ready, rw_reg, reg_write, wr_data, rs1_reg, m_valid, m_data, m_idx, busy, done
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// Bulk-loads registers 1..31 from a valid/ready stream, or dumps registers 0..31 to one.
// Writes issue one cycle after each load handshake; dump words are held until m_ready (1 word / 2 cycles).
module reg_file_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                  i_clk,
  input logic                  i_rst,
  reg_file_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, DUMP_RD, DUMP_WAIT, DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rw_reg_q, rw_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_idx_q, m_idx_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      reg_write_q <= 1'b0;
      rw_reg_q    <= '0;
      wr_data_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_idx_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reg_write_q <= reg_write_d;
      rw_reg_q    <= rw_reg_d;
      wr_data_q   <= wr_data_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_idx_q     <= m_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    reg_write_d = 1'b0;
    rw_reg_d    = rw_reg_q;
    wr_data_d   = wr_data_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_idx_d     = m_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start_load) begin
          state_d = LOAD;
          idx_d   = ADDR_W'(1);
        end else if (bus.i_start_dump) begin
          state_d = DUMP_RD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        // A handshake coinciding with abort still commits its write.
        if (bus.s_valid) begin
          reg_write_d = 1'b1;
          rw_reg_d    = idx_q;
          wr_data_d   = bus.s_data;
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + ADDR_W'(1);
        end
        if (bus.i_abort) state_d = IDLE;
      end
      DUMP_RD: begin
        if (bus.i_abort) begin
          state_d = IDLE;
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = bus.rs1_read;
          m_idx_d   = idx_q;
          state_d   = DUMP_WAIT;
        end
      end
      DUMP_WAIT: begin
        if (bus.i_abort) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
        end else if (bus.m_ready) begin
          m_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = DUMP_RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = (state_q == LOAD);
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.rs1_reg = (state_q == DUMP_RD || state_q == DUMP_WAIT) ? idx_q : '0;
  end

  assign bus.reg_write = reg_write_q;
  assign bus.rw_reg    = rw_reg_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_idx     = m_idx_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Scoreboard bench for reg_file_sequencer: expected writes/dump words are queued when
// stimulus is driven and popped when the DUT emits them; a small register-file model feeds rs1_read.
module tb_reg_file_sequencer;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [31:0] rf [32];
  exp_t exp_wr[$];
  exp_t exp_dump[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  assign bus.rs1_read = rf[bus.rs1_reg];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int n);
    exp_t e;
    e.idx = 5'(n);
    e.dat = 32'(100 + n);
    exp_wr.push_back(e);
  endtask

  task automatic push_dump(input int n);
    exp_t e;
    e.idx = 5'(n);
    e.dat = (n == 0) ? 32'd0 : 32'(100 + n);
    exp_dump.push_back(e);
  endtask

  always @(posedge clk)
    if (bus.reg_write === 1'b1) rf[bus.rw_reg] <= bus.wr_data;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.reg_write === 1'b1) begin
        chk("wr_idx_nonzero", bus.rw_reg != 5'd0, 1);
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", bus.reg_write, 0);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_idx", bus.rw_reg, mon_e.idx);
          chk("wr_data", bus.wr_data, mon_e.dat);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        if (exp_dump.size() == 0) begin
          chk("dump_unexpected", bus.m_valid, 0);
        end else begin
          mon_e = exp_dump.pop_front();
          chk("dump_idx", bus.m_idx, mon_e.idx);
          chk("dump_data", bus.m_data, mon_e.dat);
        end
      end
      if (bus.done === 1'b1) n_done++;
    end
  end

  task automatic do_load(input int n_beats, input bit abort_last, input bit both);
    tick();
    bus.i_start_load = 1'b1;
    bus.i_start_dump = both;
    tick();
    bus.i_start_load = 1'b0;
    bus.i_start_dump = 1'b0;
    chk("load_s_ready", bus.s_ready, 1);
    chk("load_rs1_zero", bus.rs1_reg, 0);
    for (int n = 1; n <= n_beats; n++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(100 + n);
      push_wr(n);
      if (n == n_beats && abort_last) bus.i_abort = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.i_abort = 1'b0;
    if (abort_last) begin
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      repeat (3) tick();
    end else begin
      chk("load_done", bus.done, 1);
      chk("load_done_busy", bus.busy, 1);
      tick();
      chk("load_idle_done", bus.done, 0);
      chk("load_idle_busy", bus.busy, 0);
    end
    chk("wr_queue_empty", exp_wr.size(), 0);
  endtask

  task automatic do_dump(input string tag, input int exp_cyc, input int stall_at);
    int  c;
    bit  stalled;
    c = 0;
    stalled = 1'b0;
    tick();
    bus.i_start_dump = 1'b1;
    bus.m_ready      = 1'b1;
    for (int n = 0; n < 32; n++) push_dump(n);
    tick();
    bus.i_start_dump = 1'b0;
    chk("dump_rs1_start", bus.rs1_reg, 0);
    while (c < 300) begin
      if (stall_at >= 0 && !stalled && bus.m_valid === 1'b1 && bus.m_idx == 5'(stall_at)) begin
        bus.m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          c++;
          chk("stall_vld", bus.m_valid, 1);
          chk("stall_dat", bus.m_data, 100 + stall_at);
          chk("stall_idx", bus.m_idx, stall_at);
        end
        bus.m_ready = 1'b1;
        stalled = 1'b1;
      end
      tick();
      c++;
      if (bus.done === 1'b1) break;
    end
    chk(tag, c, exp_cyc);
    tick();
    chk("dump_idle_busy", bus.busy, 0);
    chk("dump_queue_empty", exp_dump.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    bus.i_start_load = 1'b0;
    bus.i_start_dump = 1'b0;
    bus.i_abort      = 1'b0;
    bus.s_valid      = 1'b0;
    bus.s_data       = 32'd0;
    bus.m_ready      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_rs1", bus.rs1_reg, 0);
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_m_valid", bus.m_valid, 0);

    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("idle_abort_busy", bus.busy, 0);

    do_load(31, 1'b0, 1'b0);
    do_dump("dump_cycles", 64, -1);
    do_dump("stall_cycles", 69, 7);
    do_load(10, 1'b1, 1'b1);
    do_dump("dump_after_abort_cycles", 64, -1);

    // Reset mid-dump while word 12 is waiting for m_ready.
    tick();
    bus.i_start_dump = 1'b1;
    bus.m_ready      = 1'b1;
    for (int n = 0; n < 12; n++) push_dump(n);
    tick();
    bus.i_start_dump = 1'b0;
    c = 0;
    while (c < 100 && !(bus.m_valid === 1'b1 && bus.m_idx == 5'd12)) begin
      tick();
      c++;
    end
    chk("rst_reach_idx12", bus.m_idx, 12);
    bus.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_s_ready", bus.s_ready, 0);
    chk("mid_rst_rs1", bus.rs1_reg, 0);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    chk("mid_rst_m_idx", bus.m_idx, 0);
    chk("mid_rst_reg_write", bus.reg_write, 0);
    chk("mid_rst_rw_reg", bus.rw_reg, 0);
    chk("mid_rst_wr_data", bus.wr_data, 0);
    tick();
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_dump_q", exp_dump.size(), 0);

    chk("reg0_untouched", rf[0], 0);
    chk("done_pulses", n_done, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sequencer.md
REG_FILE_SEQUENCER -- requirements
Module: reg_file_sequencer

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 5, register index width; register count is 2^ADDR_W (32).
REQ-003 Clock and reset SHALL be one clock and a synchronous, active-high reset: i_clk  in  1  sole clock, rising edge; i_rst  in  1  synchronous active-high reset.
REQ-004 i_start_load  in  1  request bulk load of registers 1..31.
REQ-005 i_start_dump  in  1  request read-out of registers 0..31.
REQ-006 i_abort  in  1  abandon current operation.
REQ-007 s_valid  in  1  load word valid.
REQ-008 s_data  in  DATA_W  load word.
REQ-009 s_ready  out  1  load word accepted when s_valid&&s_ready.
REQ-010 rw_reg  out  ADDR_W  register file write index (registered).
REQ-011 reg_write  out  1  register file write enable (registered).
REQ-012 wr_data  out  DATA_W  register file write data (registered).
REQ-013 rs1_reg  out  ADDR_W  register file read index.
REQ-014 rs1_read  in  DATA_W  register file combinational read data for rs1_reg.
REQ-015 m_valid  out  1  dump word valid.
REQ-016 m_data  out  DATA_W  dump word.
REQ-017 m_idx  out  ADDR_W  register index of m_data.
REQ-018 m_ready  in  1  dump consumer ready.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 done  out  1  one-cycle pulse on normal completion.

Function
REQ-021 FSM states SHALL be: IDLE, LOAD, DUMP_RD, DUMP_WAIT, DONE.
REQ-022 IDLE: i_start_load -> LOAD with idx=1; else i_start_dump -> DUMP_RD with idx=0; both high -> LOAD wins.
REQ-023 Start inputs SHALL be ignored outside IDLE.
REQ-024 s_ready SHALL equal (state==LOAD) combinationally.
REQ-025 LOAD handshake: next cycle reg_write=1, rw_reg=idx, wr_data=s_data for exactly one cycle; reg_write=0 in all other cycles; s_valid low -> no write, idx held.
REQ-026 Register 0 SHALL never be written (rw_reg=0 never accompanies reg_write=1).
REQ-027 LOAD handshake with idx=31 -> DONE; otherwise idx+1; load of 31 words at 1 word/cycle takes 31 accepted beats.
REQ-028 rs1_reg SHALL equal idx in DUMP_RD and DUMP_WAIT, and 0 otherwise.
REQ-029 DUMP_RD: one cycle; at its edge capture m_data=rs1_read, m_idx=idx, m_valid=1, go to DUMP_WAIT.
REQ-030 DUMP_WAIT: m_valid, m_data and m_idx held stable until m_ready; on m_valid&&m_ready m_valid falls next cycle; idx==31 -> DONE, else idx+1 -> DUMP_RD; max throughput 1 word per 2 cycles.
REQ-031 DONE: done=1 for one cycle, busy=1, then IDLE.
REQ-032 i_abort in LOAD/DUMP_RD/DUMP_WAIT -> IDLE next cycle; no done pulse; m_valid cleared; a write from a handshake in the abort cycle itself SHALL still issue; no further writes.
REQ-033 i_abort in IDLE or DONE SHALL have no effect.
REQ-034 idx SHALL be ADDR_W bits; no wrap past 31 (completion precedes wrap).

Reset
REQ-035 i_rst high at a rising edge SHALL force state=IDLE, idx=0, reg_write=0, rw_reg=0, wr_data=0, m_valid=0, m_data=0, m_idx=0, done=0; busy=0, s_ready=0, rs1_reg=0 follow.
REQ-036 Reset SHALL take priority over i_abort, starts and handshakes, including mid-operation; no write issues in the cycle after reset.

Verification
REQ-037 Load, s_valid held high with s_data=100+n on beat n -> reg_write pulses 31 consecutive cycles, rw_reg 1..31, wr_data 101..131; done once; reg 0 untouched.
REQ-038 Dump after load, m_ready=1 -> 32 words, m_idx 0..31, m_data 0,101..131, one word every 2 cycles, done once.
REQ-039 Dump with m_ready low 5 cycles at idx=7 -> m_valid, m_data=107, m_idx=7 held stable 5 cycles, no skipped or repeated index.
REQ-040 i_start_load and i_start_dump both high in IDLE -> s_ready=1 next cycle, rs1_reg stays 0.
REQ-041 i_abort after 10 load beats -> exactly 10 writes (rw_reg 1..10), busy=0 next cycle, no done; new dump then starts cleanly at idx=0.
REQ-042 i_rst asserted during DUMP_WAIT at idx=12 -> next cycle all outputs at reset values; no done pulse.
